// File: rtl/queue_drain_reader.sv
// Consumer end of a circular queue: dequeues burst_len entries and streams them out on valid/ready.
// Optional flush port is compiled in when QDR_FLUSH_EN is defined.
module queue_drain_reader #(
    parameter int WIDTH      = 32,
    parameter int SKID_DEPTH = 2,
    parameter int BURST_MAX  = 8,
    localparam int BL_W      = $clog2(BURST_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BL_W-1:0]  burst_len,
`ifdef QDR_FLUSH_EN
    input  logic             flush,
`endif
    output logic             busy,
    output logic             done,
    output logic [BL_W-1:0]  drained_count,
    input  logic             q_empty,
    output logic             q_deq,
    input  logic             q_ready,
    input  logic [WIDTH-1:0] q_out,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready
);
    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state;
    logic [BL_W-1:0]  len_r;
    logic [BL_W-1:0]  len_sat;
    logic [BL_W-1:0]  issued;
    logic [BL_W-1:0]  issued_nxt;
    logic [BL_W-1:0]  drained_nxt;
    logic             inflight;
    logic             push;
    logic             pop;
    logic             miss;
    logic             flush_act;
    logic [WIDTH-1:0] skid [SKID_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] skid_count;
    int               occupancy;

`ifdef QDR_FLUSH_EN
    assign flush_act = flush && (state == ISSUE || state == DRAIN);
`else
    assign flush_act = 1'b0;
`endif

    assign len_sat     = (burst_len > BL_W'(BURST_MAX)) ? BL_W'(BURST_MAX) : burst_len;
    assign m_valid     = (skid_count != '0);
    assign m_data      = skid[rd_ptr];
    assign pop         = m_valid && m_ready;
    assign push        = inflight && q_ready && !flush_act;
    assign miss        = inflight && !q_ready;
    // Entries the skid buffer will hold next cycle if nothing new is requested now.
    assign occupancy   = int'(skid_count) + int'(inflight) - int'(pop);
    assign issued_nxt  = issued + BL_W'(q_deq) - BL_W'(miss);
    assign drained_nxt = drained_count + BL_W'(pop);

    always_comb begin
        q_deq = 1'b0;
        if (state == ISSUE && !flush_act && !q_empty &&
            issued < len_r && occupancy < SKID_DEPTH)
            q_deq = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            drained_count <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            len_r         <= '0;
        end else begin
            done     <= 1'b0;
            inflight <= q_deq;
            issued   <= issued_nxt;
            if (pop)
                drained_count <= drained_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_r         <= len_sat;
                        issued        <= '0;
                        drained_count <= '0;
                        busy          <= 1'b1;
                        if (len_sat == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE, DRAIN: begin
                    if (flush_act || drained_nxt == len_r) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (state == ISSUE && issued == len_r) begin
                        state <= DRAIN;
                    end else if (state == DRAIN && issued_nxt != len_r) begin
                        // An empty-miss returned a credit; go back and re-request it.
                        state <= ISSUE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++)
                skid[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            skid_count <= '0;
        end else if (flush_act) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            skid_count <= '0;
        end else begin
            if (push) begin
                skid[wr_ptr] <= q_out;
                wr_ptr <= (wr_ptr == PTR_W'(SKID_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(SKID_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            skid_count <= skid_count + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_queue_drain_reader.sv
// Scoreboard bench for queue_drain_reader with a behavioural circular-queue model on the dequeue side.
module tb_queue_drain_reader;
    localparam int WIDTH      = 32;
    localparam int SKID_DEPTH = 2;
    localparam int BURST_MAX  = 8;
    localparam int BL_W       = $clog2(BURST_MAX + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [BL_W-1:0]  burst_len;
    logic             busy;
    logic             done;
    logic [BL_W-1:0]  drained_count;
    logic             q_empty;
    logic             q_deq;
    logic             q_ready = 1'b0;
    logic [WIDTH-1:0] q_out = '0;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
`ifdef QDR_FLUSH_EN
    logic             flush = 1'b0;
`endif

    always #5 clk = ~clk;

    queue_drain_reader #(.WIDTH(WIDTH), .SKID_DEPTH(SKID_DEPTH), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
`ifdef QDR_FLUSH_EN
        .flush(flush),
`endif
        .busy(busy), .done(done), .drained_count(drained_count),
        .q_empty(q_empty), .q_deq(q_deq), .q_ready(q_ready), .q_out(q_out),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
    );

    // Queue model: dequeued data and q_ready appear the cycle after q_deq.
    logic [WIDTH-1:0] mem [0:63];
    int head = 0;
    int tail = 0;
    int miss_req = 0;
    int miss_used = 0;
    assign q_empty = (head == tail);

    always @(posedge clk) begin
        if (q_deq) begin
            if (miss_used < miss_req) begin
                q_ready   <= 1'b0;
                miss_used <= miss_used + 1;
            end else if (head != tail) begin
                q_out   <= mem[head];
                q_ready <= 1'b1;
                head    <= head + 1;
            end else begin
                q_ready <= 1'b0;
            end
        end
    end

    int cyc = 0;
    int t0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] d;
        int               c;
    } exp_t;
    exp_t sb[$];

    int               deq_cnt = 0;
    int               done_cnt = 0;
    int               done_cyc = 0;
    int               mvalid_cnt = 0;
    logic             hold_vld = 1'b0;
    logic [WIDTH-1:0] hold_dat = '0;
    exp_t             mon_e;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got %h expected none", m_data);
            end else begin
                mon_e = sb.pop_front();
                n_checks--;
                check("beat_data", m_data, mon_e.d);
                if (mon_e.c >= 0)
                    check("beat_cycle", cyc - t0 + 1, mon_e.c);
            end
        end
        if (hold_vld && m_valid)
            check("m_data_stable", m_data, hold_dat);
        hold_vld = m_valid && !m_ready && !rst;
        hold_dat = m_data;
        if (q_deq) begin
            deq_cnt++;
            check("q_deq_while_empty", q_empty, 1'b0);
        end
        if (m_valid)
            mvalid_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc - t0 + 1;
        end
    end

    task automatic enq(input logic [WIDTH-1:0] d);
        mem[tail] = d;
        tail = tail + 1;
    endtask

    task automatic expect_beat(input logic [WIDTH-1:0] d, input int c);
        exp_t e;
        e.d = d;
        e.c = c;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [BL_W-1:0] len);
        start = 1'b1;
        burst_len = len;
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int  c0;
        bit  seen;
        c0 = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt != c0)
                seen = 1'b1;
        end
        check("done_seen", seen, 1'b1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    int deq0;
    int done0;
    int mv0;
    bit hit;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        burst_len = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_q_deq", q_deq, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 32'h0);
        check("rst_drained", drained_count, 4'd0);

        // Four-entry burst, no backpressure: beats on cycles 3..6, done on 7.
        enq(32'hA000_000A); enq(32'hB000_000B); enq(32'hC000_000C); enq(32'hD000_000D);
        expect_beat(32'hA000_000A, 3); expect_beat(32'hB000_000B, 4);
        expect_beat(32'hC000_000C, 5); expect_beat(32'hD000_000D, 6);
        do_start(4'd4);
        check("t1_busy", busy, 1'b1);
        wait_done(20);
        check("t1_done_cycle", done_cyc, 7);
        check("t1_drained", drained_count, 4'd4);
        check("t1_idle_busy", busy, 1'b0);

        // Downstream stalled for 10 cycles: requests stop once the skid buffer is committed.
        enq(32'h5100_0001); enq(32'h5200_0002); enq(32'h5300_0003);
        expect_beat(32'h5100_0001, -1); expect_beat(32'h5200_0002, -1); expect_beat(32'h5300_0003, -1);
        m_ready = 1'b0;
        deq0 = deq_cnt;
        do_start(4'd3);
        repeat (9) @(posedge clk);
        #1;
        check("t2_stall_deqs", deq_cnt - deq0, SKID_DEPTH);
        check("t2_stall_valid", m_valid, 1'b1);
        m_ready = 1'b1;
        wait_done(30);
        check("t2_total_deqs", deq_cnt - deq0, 3);
        check("t2_drained", drained_count, 4'd3);

        // Empty queue at start; producer supplies X at cycle 5 and Y at cycle 9.
        expect_beat(32'h0000_00EE, -1); expect_beat(32'h0000_00FF, -1);
        deq0 = deq_cnt;
        do_start(4'd2);
        repeat (4) @(posedge clk);
        #1;
        check("t3_no_deq_while_empty", deq_cnt - deq0, 0);
        enq(32'h0000_00EE);
        repeat (4) @(posedge clk);
        #1;
        check("t3_busy_waiting", busy, 1'b1);
        enq(32'h0000_00FF);
        wait_done(20);
        check("t3_total_deqs", deq_cnt - deq0, 2);
        check("t3_drained", drained_count, 4'd2);

        // Zero-length burst: a done pulse and no queue or stream activity.
        deq0 = deq_cnt;
        done0 = done_cnt;
        mv0 = mvalid_cnt;
        do_start(4'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_done_pulses", done_cnt - done0, 1);
        check("t4_no_deq", deq_cnt - deq0, 0);
        check("t4_no_valid", mvalid_cnt - mv0, 0);
        check("t4_busy", busy, 1'b0);

        // Empty-miss on the first return: the entry is re-requested and order is preserved.
        enq(32'h7000_0001); enq(32'h7000_0002);
        expect_beat(32'h7000_0001, -1); expect_beat(32'h7000_0002, -1);
        miss_req = miss_req + 1;
        do_start(4'd2);
        wait_done(20);
        check("t5_drained", drained_count, 4'd2);

        // Reset during cycle 2 of a burst: two entries are lost in flight, no done.
        enq(32'hE000_0000); enq(32'hE000_0001); enq(32'hE000_0002); enq(32'hE000_0003);
        done0 = done_cnt;
        do_start(4'd4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_busy", busy, 1'b0);
        check("t6_done", done, 1'b0);
        check("t6_q_deq", q_deq, 1'b0);
        check("t6_m_valid", m_valid, 1'b0);
        check("t6_m_data", m_data, 32'h0);
        check("t6_drained", drained_count, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_done", done_cnt - done0, 0);
        enq(32'hF000_0000); enq(32'hF000_0001);
        expect_beat(32'hE000_0002, -1); expect_beat(32'hE000_0003, -1);
        expect_beat(32'hF000_0000, -1); expect_beat(32'hF000_0001, -1);
        do_start(4'd4);
        wait_done(20);
        check("t6_restart_drained", drained_count, 4'd4);

`ifdef QDR_FLUSH_EN
        // Flush after three accepted beats of an eight-entry burst.
        for (int i = 0; i < 8; i++)
            enq(32'h6000_0000 + i);
        expect_beat(32'h6000_0000, -1); expect_beat(32'h6000_0001, -1); expect_beat(32'h6000_0002, -1);
        do_start(4'd8);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (drained_count == 4'd3)
                hit = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("t7_reached_three", hit, 1'b1);
        done0 = done_cnt;
        flush = 1'b1;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("t7_m_valid_dropped", m_valid, 1'b0);
        check("t7_done", done, 1'b1);
        check("t7_drained", drained_count, 4'd3);
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t7_done_pulses", done_cnt - done0, 1);
        check("t7_busy", busy, 1'b0);
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
